// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core: register and Tuse/Tnew widths,
// mult/div latencies and a per-source hazard compare helper.
package mips_pkg;

   localparam int unsigned REG_W        = 5;
   localparam int unsigned TW           = 2;
   localparam int unsigned MD_CNT_W     = 4;
   localparam int unsigned STALL_CNT_W  = 32;
   localparam int unsigned MULT_CYC_DEF = 5;
   localparam int unsigned DIV_CYC_DEF  = 10;

   localparam logic [TW-1:0]    TUSE_NONE = TW'(3);
   localparam logic [REG_W-1:0] REG_ZERO  = REG_W'(0);

   typedef logic [REG_W-1:0] reg_addr_t;
   typedef logic [TW-1:0]    tval_t;

   // A source stalls when a younger-stage producer of the same register
   // delivers its result later than the ID instruction needs it.
   function automatic logic src_stall(input reg_addr_t src,
                                      input tval_t     tuse,
                                      input reg_addr_t wa_e,
                                      input tval_t     tnew_e,
                                      input reg_addr_t wa_m,
                                      input tval_t     tnew_m);
      logic hit_e;
      logic hit_m;
      hit_e = (src == wa_e) && (tnew_e > tuse);
      hit_m = (src == wa_m) && (tnew_m > tuse);
      return (src != REG_ZERO) && (hit_e || hit_m);
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: loads the unit latency on each start (a start
// while busy simply reloads) and counts down to idle.
module md_busy_timer
   import mips_pkg::*;
#(
   parameter int unsigned MULT_CYC = MULT_CYC_DEF,
   parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic md_start_i,
   input  logic md_div_i,
   output logic md_busy_o
);

   logic [MD_CNT_W-1:0] cnt_q;
   logic [MD_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (md_start_i) begin
         cnt_d = md_div_i ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - MD_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: Tuse/Tnew data-hazard detection, mult/div
// occupancy interlock, PC/IF-ID/ID-EX control and a saturating stall counter.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MULT_CYC = MULT_CYC_DEF,
   parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [REG_W-1:0]       rs_d,
   input  logic [REG_W-1:0]       rt_d,
   input  logic [TW-1:0]          tuse_rs_d,
   input  logic [TW-1:0]          tuse_rt_d,
   input  logic                   md_use_d,
   input  logic [REG_W-1:0]       wa_e,
   input  logic [TW-1:0]          tnew_e,
   input  logic [REG_W-1:0]       wa_m,
   input  logic [TW-1:0]          tnew_m,
   input  logic                   md_start_e,
   input  logic                   md_div_e,
   output logic                   pc_en,
   output logic                   ifid_en,
   output logic                   idex_clr,
   output logic                   md_busy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic stall_rs;
   logic stall_rt;
   logic stall_md;
   logic stall;

   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d;

   md_busy_timer #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_busy_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .md_start_i (md_start_e),
      .md_div_i   (md_div_e),
      .md_busy_o  (md_busy)
   );

   // Stall decision is purely combinational so the bubble lands this cycle.
   always_comb begin
      stall_rs = src_stall(rs_d, tuse_rs_d, wa_e, tnew_e, wa_m, tnew_m);
      stall_rt = src_stall(rt_d, tuse_rt_d, wa_e, tnew_e, wa_m, tnew_m);
      stall_md = md_use_d && (md_busy || md_start_e);
      stall    = stall_rs || stall_rt || stall_md;
   end

   assign pc_en    = ~stall;
   assign ifid_en  = ~stall;
   assign idex_clr = stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: cycle-indexed behavioural model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs_d, rt_d, wa_e, wa_m;
   logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
   logic        md_use_d, md_start_e, md_div_e;
   logic        pc_en, ifid_en, idex_clr, md_busy;
   logic [31:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rs_d       (rs_d),
      .rt_d       (rt_d),
      .tuse_rs_d  (tuse_rs_d),
      .tuse_rt_d  (tuse_rt_d),
      .md_use_d   (md_use_d),
      .wa_e       (wa_e),
      .tnew_e     (tnew_e),
      .wa_m       (wa_m),
      .tnew_m     (tnew_m),
      .md_start_e (md_start_e),
      .md_div_e   (md_div_e),
      .pc_en      (pc_en),
      .ifid_en    (ifid_en),
      .idex_clr   (idex_clr),
      .md_busy    (md_busy),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: cycle index, last mult/div start (cycle + latency), counter.
   int          cyc = 0;
   bit          st_valid = 0;
   int          st_cyc = 0;
   int          st_len = 0;
   longint      m_cnt = 0;

   function automatic bit m_busy();
      return st_valid && (cyc > st_cyc) && (cyc <= st_cyc + st_len);
   endfunction

   function automatic bit m_src(input int src, input int tuse);
      if (src == 0) return 0;
      if (src == int'(wa_e) && int'(tnew_e) > tuse) return 1;
      if (src == int'(wa_m) && int'(tnew_m) > tuse) return 1;
      return 0;
   endfunction

   function automatic bit m_stall();
      bit s_md;
      s_md = md_use_d && (m_busy() || md_start_e);
      return m_src(int'(rs_d), int'(tuse_rs_d)) || m_src(int'(rt_d), int'(tuse_rt_d)) || s_md;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_valid = 0;
         m_cnt    = 0;
      end else begin
         if (m_stall() && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (md_start_e) begin
            st_valid = 1;
            st_cyc   = cyc;
            st_len   = md_div_e ? 10 : 5;
         end
      end
      if (rst_n) cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("model.pc_en",     32'(pc_en),    32'(!m_stall()));
         chk("model.ifid_en",   32'(ifid_en),  32'(!m_stall()));
         chk("model.idex_clr",  32'(idex_clr), 32'(m_stall()));
         chk("model.md_busy",   32'(md_busy),  32'(m_busy()));
         chk("model.stall_cnt", stall_cnt,     m_cnt[31:0]);
      end
   end

   task automatic clear_in();
      rs_d = 0; rt_d = 0; tuse_rs_d = 2'd3; tuse_rt_d = 2'd3; md_use_d = 0;
      wa_e = 0; tnew_e = 0; wa_m = 0; tnew_m = 0; md_start_e = 0; md_div_e = 0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      #1;
      clear_in();
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0;
      clear_in();
      tuse_rs_d = 0; tuse_rt_d = 0;
      #12;
      chk("rst.md_busy",   32'(md_busy),   32'd0);
      chk("rst.stall_cnt", stall_cnt,      32'd0);
      chk("rst.pc_en",     32'(pc_en),     32'd1);
      chk("rst.idex_clr",  32'(idex_clr),  32'd0);
      next_cyc();
      rst_n = 1;
      @(negedge clk);
      chk("rel.pc_en",     32'(pc_en),     32'd1);
      chk("rel.ifid_en",   32'(ifid_en),   32'd1);
      chk("rel.stall_cnt", stall_cnt,      32'd0);

      // Load-use: stall one cycle, then MEM stage value resolves in time.
      next_cyc();
      clear_in();
      rs_d = 8; wa_e = 8; tnew_e = 2; tuse_rs_d = 1;
      @(negedge clk);
      chk("lu.stall_pc_en",  32'(pc_en),    32'd0);
      chk("lu.stall_clr",    32'(idex_clr), 32'd1);
      next_cyc();
      wa_e = 0; tnew_e = 0; wa_m = 8; tnew_m = 1;
      @(negedge clk);
      chk("lu.resolved_pc_en", 32'(pc_en), 32'd1);
      chk("lu.stall_cnt",      stall_cnt,  32'd1);

      // Register 0 never stalls.
      next_cyc();
      clear_in();
      rs_d = 0; wa_e = 0; tnew_e = 2; tuse_rs_d = 0;
      @(negedge clk);
      chk("r0.pc_en", 32'(pc_en), 32'd1);

      // rt path and MEM-stage hazard.
      next_cyc();
      clear_in();
      rt_d = 5'd31; tuse_rt_d = 0; wa_m = 5'd31; tnew_m = 1;
      @(negedge clk);
      chk("rt_m.idex_clr", 32'(idex_clr), 32'd1);
      next_cyc();
      rt_d = 5'd30;
      @(negedge clk);
      chk("rt_m.neq_pc_en", 32'(pc_en), 32'd1);

      // Mult start with mult/div user held in ID: stall t..t+5.
      do_reset();
      md_use_d = 1; md_start_e = 1; md_div_e = 0;
      @(negedge clk);
      chk("mult.t_stall", 32'(idex_clr), 32'd1);
      for (int i = 1; i <= 5; i++) begin
         next_cyc();
         md_start_e = 0;
         @(negedge clk);
         chk("mult.busy", 32'(md_busy), 32'd1);
         chk("mult.held", 32'(pc_en),   32'd0);
      end
      next_cyc();
      @(negedge clk);
      chk("mult.release_busy", 32'(md_busy), 32'd0);
      chk("mult.release_en",   32'(pc_en),   32'd1);
      chk("mult.stall_cnt",    stall_cnt,    32'd6);

      // Reload override: div restart while a mult is still counting.
      next_cyc();
      md_use_d = 0; md_start_e = 1; md_div_e = 0;
      next_cyc();
      md_start_e = 0;
      next_cyc();
      md_start_e = 1; md_div_e = 1;
      next_cyc();
      md_start_e = 0; md_div_e = 0;
      for (int i = 0; i < 11; i++) next_cyc();
      @(negedge clk);
      chk("reload.idle", 32'(md_busy), 32'd0);

      // Div start, async reset mid-operation.
      do_reset();
      md_start_e = 1; md_div_e = 1; md_use_d = 1;
      next_cyc();
      md_start_e = 0; md_div_e = 0;
      next_cyc();
      next_cyc();
      @(negedge clk);
      chk("div.busy_pre", 32'(md_busy), 32'd1);
      #2;
      rst_n = 0;
      #1;
      chk("div.rst_busy", 32'(md_busy),   32'd0);
      chk("div.rst_cnt",  stall_cnt,      32'd0);
      next_cyc();
      rst_n = 1;
      @(negedge clk);
      chk("div.after_en",  32'(pc_en), 32'd1);
      chk("div.after_cnt", stall_cnt,  32'd0);

      // Saturation: preload just below the limit while not stalling.
      next_cyc();
      clear_in();
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      m_cnt = 64'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      #1;
      md_use_d = 1; md_start_e = 1;
      next_cyc();
      @(negedge clk);
      chk("sat.reach", stall_cnt, 32'hFFFF_FFFF);
      next_cyc();
      md_start_e = 0;
      next_cyc();
      @(negedge clk);
      chk("sat.hold", stall_cnt, 32'hFFFF_FFFF);

      clear_in();
      next_cyc();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. Compares ID-stage source registers against in-flight EX/MEM destinations using Tuse/Tnew timing, and tracks the multi-cycle mult/div unit with an internal busy timer. Drives the enable of the PC and IF/ID registers and the clear of the ID/EX register. Also keeps a saturating stall-cycle counter for performance checks.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu issues.
- DIV_CYC, 10, busy cycles after a div/divu issues.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs_d  in  5  ID rs address.
- rt_d  in  5  ID rt address.
- tuse_rs_d  in  2  cycles until ID instr needs rs (3 = not used).
- tuse_rt_d  in  2  same for rt.
- md_use_d  in  1  ID instr is mult/div/mfhi/mflo/mthi/mtlo.
- wa_e  in  5  EX destination register (0 = none).
- tnew_e  in  2  EX cycles until result ready.
- wa_m  in  5  MEM destination register.
- tnew_m  in  2  MEM cycles until result ready.
- md_start_e  in  1  EX holds a mult/div starting this cycle.
- md_div_e  in  1  qualifies md_start_e: 1 = div/divu, 0 = mult/multu.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- idex_clr  out  1  ID/EX clear (inject bubble).
- md_busy  out  1  mult/div unit occupied.
- stall_cnt  out  32  total stalled cycles, saturating.

## Operation
- stall_rs = (rs_d != 0) && ((rs_d == wa_e && tnew_e > tuse_rs_d) || (rs_d == wa_m && tnew_m > tuse_rs_d)).
- stall_rt: same as stall_rs, using rt_d and tuse_rt_d.
- stall_md = md_use_d && (md_busy || md_start_e).
- stall = stall_rs | stall_rt | stall_md.
- pc_en = ifid_en = ~stall; idex_clr = stall. All three are combinational, with no registered delay.
- Busy timer: 4-bit down-counter cnt.
  - On md_start_e, load cnt with DIV_CYC if md_div_e, else MULT_CYC.
  - Otherwise, if cnt != 0, decrement.
  - md_busy = (cnt != 0).
- md_start_e while md_busy: counter reloads; this is a legal override, not an error.
- stall_cnt increments at each clk edge where stall = 1. It holds at 32'hFFFF_FFFF.
- Comparisons use full 5-bit equality. Register 0 never causes a stall.

## Timing
- Reset (rst_n low, any cycle including mid-mult/div):
  - cnt = 0, md_busy = 0, stall_cnt = 0 immediately.
  - With all-zero inputs: pc_en = 1, ifid_en = 1, idex_clr = 0.
- md_start_e high in cycle t:
  - stall_md covers cycle t through the md_start_e term.
  - md_busy is high in cycles t+1 … t+N, where N = MULT_CYC or DIV_CYC.
  - md_busy is low in cycle t+N+1.
- A stall holds for exactly the cycles in which the condition is true. There is no hysteresis and no added latency.
- Load-use case (lw in EX, tnew_e = 2; user in ID, tuse = 0 or 1): stalls; the next cycle is re-evaluated with MEM values.

## Structure
- Shared mips_pkg holds:
  - Tuse/Tnew width (2).
  - TUSE_NONE = 3.
  - Default MULT_CYC and DIV_CYC.
  - Register-0 constant.
- One sub-module, md_busy_timer: counter, reload, md_busy.
- Hazard compare logic and stall_cnt stay in hazard_ctrl.

## Test plan
- Reset release, all inputs 0 -> pc_en = 1, ifid_en = 1, idex_clr = 0, md_busy = 0, stall_cnt = 0.
- rs_d = 8, wa_e = 8, tnew_e = 2, tuse_rs_d = 1 -> stall for 1 cycle; next cycle wa_m = 8, tnew_m = 1 -> no stall; stall_cnt = 1.
- rs_d = 0, wa_e = 0, tnew_e = 2, tuse_rs_d = 0 -> no stall.
- md_start_e = 1, md_div_e = 0 at t; md_use_d = 1 held -> stall for t … t+5; released at t+6; stall_cnt = 6.
- div start, rst_n pulsed low at t+3 -> md_busy = 0 immediately, no stall after release, stall_cnt = 0.
- Force stall for > 2^32 cycles (or preload via hierarchical deposit at 32'hFFFF_FFFE) -> stall_cnt sticks at 32'hFFFF_FFFF.
